// File: rtl/vram_write_queue.sv
// CPU-to-VRAM write buffer: queues CPU byte writes and drains them into VRAM
// only while the video timing generator reports the memory as writable.

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

module vram_write_queue #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       writable,
    input  logic                       cpu_wr,
    input  logic [ADDR_WIDTH-1:0]      cpu_address,
    input  logic [7:0]                 cpu_data,
    input  logic                       clear_overflow,
    output logic                       cpu_ready,
    output logic [ADDR_WIDTH-1:0]      address,
    output logic [7:0]                 data,
    output logic                       vram_we,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [7:0]            mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic drop;
    logic pop;

    // Readiness comes only from registered count, so a full queue refuses a
    // write even when a pop frees a slot on the same edge.
    assign cpu_ready = (count < CNT_W'(DEPTH));
    assign pending   = count;

    assign push = cpu_wr && cpu_ready;
    assign drop = cpu_wr && !cpu_ready;
    assign pop  = writable && (count != '0);

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_addr[wr_ptr] <= cpu_address;
            mem_data[wr_ptr] <= cpu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            vram_we  <= 1'b0;
            address  <= '0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                address <= mem_addr[rd_ptr];
                data    <= mem_data[rd_ptr];
            end
            vram_we <= pop;

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_queue.sv
// Bench for vram_write_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on the observed VRAM writes.

module tb_vram_write_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          writable = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [7:0]    cpu_data = '0;
    logic          clear_overflow = 1'b0;
    logic          cpu_ready;
    logic [AW-1:0] address;
    logic [7:0]    data;
    logic          vram_we;
    logic [4:0]    pending;
    logic          overflow;

    vram_write_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .writable       (writable),
        .cpu_wr         (cpu_wr),
        .cpu_address    (cpu_address),
        .cpu_data       (cpu_data),
        .clear_overflow (clear_overflow),
        .cpu_ready      (cpu_ready),
        .address        (address),
        .data           (data),
        .vram_we        (vram_we),
        .pending        (pending),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    typedef struct { logic [AW-1:0] a; logic [7:0] d; } ent_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] d; int c; } wr_t;

    ent_t q[$];
    wr_t  wlog[$];

    logic          m_we = 1'b0;
    logic [AW-1:0] m_a = '0;
    logic [7:0]    m_d = '0;
    logic          m_ovf = 1'b0;
    int            n_before;
    ent_t          e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a VRAM write is the head of the queue popped one edge
    // earlier; a push only lands if the queue was not full before the edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            q.delete();
            m_we  = 1'b0;
            m_a   = '0;
            m_d   = '0;
            m_ovf = 1'b0;
        end else begin
            n_before = q.size();
            if (writable && n_before > 0) begin
                e    = q.pop_front();
                m_a  = e.a;
                m_d  = e.d;
                m_we = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (cpu_wr && n_before < DEPTH) q.push_back('{cpu_address, cpu_data});
            if (cpu_wr && n_before >= DEPTH) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vram_we", 32'(vram_we), 32'(m_we));
            chk("address", 32'(address), 32'(m_a));
            chk("data", 32'(data), 32'(m_d));
            chk("pending", 32'(pending), 32'(q.size()));
            chk("cpu_ready", 32'(cpu_ready), 32'(q.size() < DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (vram_we === 1'b1) wlog.push_back('{address, data, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_wr = 1'b1;
        cpu_address = a;
        cpu_data = d;
        tick();
        cpu_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [AW-1:0] ea [3];
        logic [7:0]    ed [3];

        // 1. reset with cpu_wr held high
        rst = 1'b0;
        cpu_wr = 1'b1;
        cpu_address = 16'h0055;
        cpu_data = 8'h55;
        idle(2);
        cpu_wr = 1'b0;
        chk("t1 vram_we", 32'(vram_we), 0);
        chk("t1 address", 32'(address), 0);
        chk("t1 data", 32'(data), 0);
        chk("t1 pending", 32'(pending), 0);
        chk("t1 overflow", 32'(overflow), 0);
        chk("t1 cpu_ready", 32'(cpu_ready), 1);
        rst = 1'b1;
        idle(2);
        chk("t1 nothing queued", 32'(pending), 0);

        // 2. queue while locked, then open the window
        writable = 1'b0;
        wr(16'h0100, 8'hAA);
        wr(16'h0101, 8'hBB);
        wr(16'h0102, 8'hCC);
        idle(2);
        chk("t2 pending", 32'(pending), 3);
        chk("t2 no write while locked", 32'(wlog.size()), 0);
        ea = '{16'h0100, 16'h0101, 16'h0102};
        ed = '{8'hAA, 8'hBB, 8'hCC};
        k = cyc;
        writable = 1'b1;
        idle(5);
        chk("t2 write count", 32'(wlog.size()), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            chk("t2 addr", 32'(wlog[i].a), 32'(ea[i]));
            chk("t2 data", 32'(wlog[i].d), 32'(ed[i]));
            chk("t2 cycle", 32'(wlog[i].c), 32'(k + 1 + i));
        end
        chk("t2 pending drained", 32'(pending), 0);
        writable = 1'b0;
        wlog.delete();

        // 3. overflow
        for (int i = 0; i < 16; i++) wr(AW'(i), 8'(8'h10 + i));
        chk("t3 cpu_ready full", 32'(cpu_ready), 0);
        chk("t3 pending full", 32'(pending), 16);
        chk("t3 overflow before drop", 32'(overflow), 0);
        wr(16'h0010, 8'h20);
        chk("t3 overflow set", 32'(overflow), 1);
        chk("t3 pending after drop", 32'(pending), 16);
        writable = 1'b1;
        idle(20);
        writable = 1'b0;
        chk("t3 drained writes", 32'(wlog.size()), 16);
        for (int i = 0; i < 16 && i < wlog.size(); i++) begin
            chk("t3 data", 32'(wlog[i].d), 32'(8'h10 + i));
            chk("t3 addr", 32'(wlog[i].a), 32'(i));
        end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("t3 overflow cleared", 32'(overflow), 0);
        wlog.delete();

        // 4. streaming
        writable = 1'b1;
        k = cyc;
        for (int i = 0; i < 40; i++) begin
            wr(AW'(16'h0200 + i), 8'(i));
            chk("t4 pending steady", 32'(pending), 1);
        end
        idle(4);
        chk("t4 write count", 32'(wlog.size()), 40);
        for (int i = 0; i < 40 && i < wlog.size(); i++) begin
            chk("t4 data", 32'(wlog[i].d), 32'(i));
            chk("t4 cycle", 32'(wlog[i].c), 32'(k + 2 + i));
        end
        writable = 1'b0;
        wlog.delete();

        // 4b. drop coinciding with clear_overflow
        for (int i = 0; i < 16; i++) wr(AW'(16'h0400 + i), 8'(i));
        wr(16'h0500, 8'hEE);
        chk("t4b overflow set", 32'(overflow), 1);
        clear_overflow = 1'b1;
        wr(16'h0501, 8'hEF);
        clear_overflow = 1'b0;
        chk("t4b set wins", 32'(overflow), 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("t4b cleared", 32'(overflow), 0);
        writable = 1'b1;
        idle(18);
        writable = 1'b0;
        chk("t4b drained", 32'(wlog.size()), 16);
        wlog.delete();

        // 5. window close
        for (int i = 0; i < 8; i++) wr(AW'(16'h0300 + i), 8'(8'h80 + i));
        k = cyc;
        writable = 1'b1;
        idle(3);
        writable = 1'b0;
        idle(3);
        chk("t5 writes in window", 32'(wlog.size()), 3);
        if (wlog.size() == 3) chk("t5 last write cycle", 32'(wlog[2].c), 32'(k + 3));
        chk("t5 pending", 32'(pending), 5);
        writable = 1'b1;
        idle(8);
        writable = 1'b0;
        chk("t5 total writes", 32'(wlog.size()), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            chk("t5 data", 32'(wlog[i].d), 32'(8'h80 + i));
            chk("t5 addr", 32'(wlog[i].a), 32'(16'h0300 + i));
        end
        wlog.delete();

        // 6. reset mid-drain
        for (int i = 0; i < 6; i++) wr(AW'(16'h0600 + i), 8'(8'h60 + i));
        writable = 1'b1;
        idle(2);
        chk("t6 writing before reset", 32'(vram_we), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6 vram_we after reset", 32'(vram_we), 0);
        chk("t6 pending after reset", 32'(pending), 0);
        idle(10);
        writable = 1'b0;
        chk("t6 no stale writes", 32'(wlog.size()), 2);
        if (wlog.size() >= 2) chk("t6 second write data", 32'(wlog[1].d), 32'(8'h61));

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_write_queue.md
# vram_write_queue

Write-side front end of the GPU's VRAM. Accepts byte writes from the CPU bus at any time, buffers them in a FIFO, and drains them into VRAM (PMF, OBM and the other pattern/object memories) only while the video timing generator reports the memory as `writable`. This keeps the renderers' reads race-free during the visible frame.

## Interface

Parameters:
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `ADDR_WIDTH`, default `` `VRAM_ADDR_WIDTH ``: VRAM address width.

Ports:
- `clk`  in  1  pixel clock, 12.5875 MHz. The block uses one clock.
- `rst`  in  1  reset; synchronous, active-low.
- `writable`  in  1  from video timing. VRAM may be written only in this window.
- `cpu_wr`  in  1  one-cycle write strobe from the CPU bus.
- `cpu_address`  in  ADDR_WIDTH  write address.
- `cpu_data`  in  8  write data.
- `clear_overflow`  in  1  clears `overflow`.
- `cpu_ready`  out  1  high when the queue can accept a write this cycle.
- `address`  out  ADDR_WIDTH  VRAM write address.
- `data`  out  8  VRAM write data.
- `vram_we`  out  1  VRAM write enable. VRAM commits `data` to `address` on a `clk` edge where this is high.
- `pending`  out  $clog2(DEPTH)+1  number of entries queued.
- `overflow`  out  1  sticky flag: a write was dropped.

## Operation

- Storage: DEPTH × {address, data}, with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a `count` register in 0..DEPTH. `pending` = `count`.
- `cpu_ready` = (`count` < DEPTH). It is decoded from registered state only and does not depend on `cpu_wr`.
- Push:
  - Condition: `cpu_wr` && `cpu_ready`.
  - Stores {`cpu_address`, `cpu_data`} at the write pointer and increments the pointer.
- Drop:
  - Condition: `cpu_wr` && !`cpu_ready`. The write is discarded and `overflow` is set.
  - There is no pass-through when full, even if a pop happens in the same cycle.
- Pop:
  - Condition: `writable` && `count` != 0.
  - Loads the head entry into the output registers `address`/`data`, sets `vram_we`=1 for the next cycle, and increments the read pointer.
  - When there is no pop, `vram_we`=0 next cycle, and `address`/`data` hold their last values.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- No bypass: an entry pushed in cycle t is first poppable in cycle t+1.
- Ordering: strict FIFO. Writes to the same address are not coalesced; every accepted write reaches VRAM exactly once.
- `overflow`:
  - Set on a drop.
  - Cleared by `clear_overflow` when no drop occurs in the same cycle.
  - If a drop and `clear_overflow` coincide, set wins.
- Reset (`rst`=0 at a clock edge):
  - `count`=0, both pointers=0, `vram_we`=0, `address`=0, `data`=0, `overflow`=0.
  - `cpu_ready` therefore reads 1 and `pending` reads 0.
  - While `rst`=0, `cpu_wr` is ignored.
  - Mid-operation reset discards all queued entries. A `vram_we` asserted in the reset cycle deasserts on the next edge.

## Timing

- Latency with empty queue and `writable` high: `cpu_wr` in cycle t → pop in t+1 → `vram_we`=1 during t+2.
- Latency with `writable` low: a queued entry pops in the first cycle `writable` is high. `vram_we` follows one cycle later.
- Throughput: one write per cycle while `writable` is high and the queue is non-empty.
- Window end: the last pop happens in the final `writable`-high cycle, so its `vram_we` falls in the cycle after `writable` drops. The video timing generator ends the `writable` window at least one clock before `visible` rises, so this write is safe.
- `pending` and `cpu_ready` update on the edge after the push or pop.

## Test plan

1. Reset: hold `rst`=0 for 2 cycles with `cpu_wr`=1 → `vram_we`=0, `address`=0, `data`=0, `pending`=0, `overflow`=0, `cpu_ready`=1. No entry is queued.
2. Queue while locked:
   - With `writable`=0, write 0x0100←0xAA, 0x0101←0xBB, 0x0102←0xCC → `pending`=3 and `vram_we` stays 0.
   - Raise `writable` at cycle w → `vram_we`=1 in cycles w+1..w+3 with these pairs in order, then `pending`=0.
3. Overflow:
   - With `writable`=0 and DEPTH=16, issue 17 writes (addr i, data 0x10+i) → after 16, `cpu_ready`=0 and `pending`=16; the 17th sets `overflow`=1.
   - Drain → exactly 16 writes, data 0x10..0x1F.
   - Pulse `clear_overflow` → `overflow`=0.
4. Streaming:
   - `writable`=1, empty queue, `cpu_wr` every cycle for 40 cycles with data 0..39 → `pending` holds at 1, and `vram_we` is high for 40 consecutive cycles starting 2 cycles after the first write, data 0..39 in order.
   - Also: drop and `clear_overflow` in the same cycle → `overflow` stays 1.
5. Window close:
   - Queue 8 entries, then hold `writable`=1 for exactly 3 cycles → exactly 3 VRAM writes, the last with `vram_we` in the cycle after `writable` falls; `pending`=5.
   - Reopen → the remaining 5 entries drain in order.
6. Reset mid-drain: queue 6 entries, open `writable`, assert `rst` after 2 writes → `vram_we`=0 on the next edge and `pending`=0. After release, no stale write appears even with `writable`=1.
